// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU operand front-end.
// Source select codes, default fixed-point geometry and per-operand flag layout.
package fpu_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_FRAC_W = 48;

    localparam logic [2:0] SRC_ZERO = 3'b000;
    localparam logic [2:0] SRC_ONE  = 3'b001;
    localparam logic [2:0] SRC_XMM  = 3'b010;
    localparam logic [2:0] SRC_FP32 = 3'b011;
    localparam logic [2:0] SRC_U32  = 3'b100;
    localparam logic [2:0] SRC_I32  = 3'b101;

    localparam int FLAG_SAT  = 0;
    localparam int FLAG_NAN  = 1;
    localparam int FLAG_BAD  = 2;
    localparam int NUM_FLAGS = 3;

    typedef logic [NUM_FLAGS-1:0] fpu_flags_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

endpackage

// File: rtl/fpu_q_convert.sv
// Combinational conversion of one operand into signed fixed point
// (DATA_W bits, FRAC_W fractional), with saturation and exception flags.
module fpu_q_convert
    import fpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic [2:0]        src_i,
    input  logic [31:0]       rs_i,
    input  logic [DATA_W-1:0] xs_i,
    output logic [DATA_W-1:0] data_o,
    output logic              sat_o,
    output logic              nan_o,
    output logic              bad_src_o
);

    localparam int INT_W = DATA_W - FRAC_W;
    // Integer compares need at least 33 bits so u32 stays positive
    localparam int EW    = (INT_W > 33) ? INT_W : 33;

    localparam logic [DATA_W-1:0]    MAX_V  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]    MIN_V  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [EW-1:0] INT_HI = EW'((64'd1 << (INT_W-1)) - 64'd1);
    localparam logic signed [EW-1:0] INT_LO = ~INT_HI;

    fp32_t                 f;
    logic signed [11:0]    sh;
    logic signed [11:0]    top;
    logic [11:0]           lsh;
    logic [11:0]           rsh;
    logic [DATA_W-1:0]     mant_ext;
    logic [DATA_W-1:0]     mag;
    logic [DATA_W-1:0]     fp_data;
    logic                  fp_sat;
    logic                  fp_nan;
    logic signed [EW-1:0]  u_val;
    logic signed [EW-1:0]  i_val;

    assign f     = rs_i;
    assign u_val = {{(EW-32){1'b0}}, rs_i};
    assign i_val = {{(EW-32){rs_i[31]}}, rs_i};

    // fp32 magnitude is {1,mant} * 2^sh; top is the bit position of its leading one
    always_comb begin
        sh       = $signed({4'b0, f.exp}) + $signed(12'(FRAC_W - 150));
        top      = sh + 12'sd23;
        lsh      = sh;
        rsh      = -sh;
        mant_ext = DATA_W'({1'b1, f.mant});
        mag      = '0;
        fp_data  = '0;
        fp_sat   = 1'b0;
        fp_nan   = 1'b0;
        if (f.exp == 8'hFF) begin
            if (f.mant != '0) begin
                fp_nan = 1'b1;
            end else begin
                fp_sat  = 1'b1;
                fp_data = f.sign ? MIN_V : MAX_V;
            end
        end else if (f.exp != 8'h00) begin
            if (top > $signed(12'(DATA_W - 1))) begin
                fp_sat  = 1'b1;
                fp_data = f.sign ? MIN_V : MAX_V;
            end else if (top == $signed(12'(DATA_W - 1))) begin
                // Magnitude >= 2^(DATA_W-1): only an exact -2^(DATA_W-1) is representable
                fp_data = f.sign ? MIN_V : MAX_V;
                fp_sat  = !f.sign || (f.mant != '0);
            end else begin
                mag     = sh[11] ? (mant_ext >> rsh) : (mant_ext << lsh);
                fp_data = f.sign ? -mag : mag;
            end
        end
    end

    always_comb begin
        data_o    = '0;
        sat_o     = 1'b0;
        nan_o     = 1'b0;
        bad_src_o = 1'b0;
        case (src_i)
            SRC_ZERO: data_o = '0;
            SRC_ONE:  data_o = DATA_W'(1) << FRAC_W;
            SRC_XMM:  data_o = xs_i;
            SRC_FP32: begin
                data_o = fp_data;
                sat_o  = fp_sat;
                nan_o  = fp_nan;
            end
            SRC_U32: begin
                if (u_val > INT_HI) begin
                    data_o = MAX_V;
                    sat_o  = 1'b1;
                end else begin
                    data_o = DATA_W'(u_val) << FRAC_W;
                end
            end
            SRC_I32: begin
                if (i_val > INT_HI) begin
                    data_o = MAX_V;
                    sat_o  = 1'b1;
                end else if (i_val < INT_LO) begin
                    data_o = MIN_V;
                    sat_o  = 1'b1;
                end else begin
                    data_o = DATA_W'(i_val) << FRAC_W;
                end
            end
            default: bad_src_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_operand_stage.sv
// Two-stage valid/ready operand front-end: stage 1 captures raw sources,
// stage 2 holds converted fixed-point operands and their flags.
module fpu_operand_stage
    import fpu_pkg::*;
#(
    parameter int NUM_OPS = 2,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAC_W  = DEF_FRAC_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3*NUM_OPS-1:0]      src,
    input  logic [32*NUM_OPS-1:0]     rs_data,
    input  logic [DATA_W*NUM_OPS-1:0] xs_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W*NUM_OPS-1:0] out_data,
    output logic [NUM_OPS-1:0]        out_sat,
    output logic [NUM_OPS-1:0]        out_nan,
    output logic [NUM_OPS-1:0]        out_bad_src
);

    logic                             s1_valid_q, s1_valid_d;
    logic [NUM_OPS-1:0][2:0]          s1_src_q,   s1_src_d;
    logic [NUM_OPS-1:0][31:0]         s1_rs_q,    s1_rs_d;
    logic [NUM_OPS-1:0][DATA_W-1:0]   s1_xs_q,    s1_xs_d;

    logic                             s2_valid_q, s2_valid_d;
    logic [NUM_OPS-1:0][DATA_W-1:0]   s2_data_q,  s2_data_d;
    fpu_flags_t [NUM_OPS-1:0]         s2_flags_q, s2_flags_d;

    logic [NUM_OPS-1:0][DATA_W-1:0]   cv_data;
    fpu_flags_t [NUM_OPS-1:0]         cv_flags;

    logic adv;
    logic accept;

    // The whole pipe shifts whenever the output slot is free or being drained
    assign adv      = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || adv;
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        fpu_q_convert #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_conv (
            .src_i     (s1_src_q[i]),
            .rs_i      (s1_rs_q[i]),
            .xs_i      (s1_xs_q[i]),
            .data_o    (cv_data[i]),
            .sat_o     (cv_flags[i][FLAG_SAT]),
            .nan_o     (cv_flags[i][FLAG_NAN]),
            .bad_src_o (cv_flags[i][FLAG_BAD])
        );

        assign out_sat[i]     = s2_flags_q[i][FLAG_SAT];
        assign out_nan[i]     = s2_flags_q[i][FLAG_NAN];
        assign out_bad_src[i] = s2_flags_q[i][FLAG_BAD];
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_src_d   = s1_src_q;
        s1_rs_d    = s1_rs_q;
        s1_xs_d    = s1_xs_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_flags_d = s2_flags_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_src_d   = src;
            s1_rs_d    = rs_data;
            s1_xs_d    = xs_data;
        end else if (adv) begin
            s1_valid_d = 1'b0;
        end

        if (adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d  = cv_data;
                s2_flags_d = cv_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= '0;
            s1_rs_q    <= '0;
            s1_xs_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_flags_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_src_q   <= s1_src_d;
            s1_rs_q    <= s1_rs_d;
            s1_xs_q    <= s1_xs_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_flags_q <= s2_flags_d;
        end
    end

endmodule

// File: tb/tb_fpu_operand_stage.sv
// Bench for fpu_operand_stage: directed table, back-pressure, reset and
// randomized streaming against a value-level reference model.
module tb_fpu_operand_stage;

    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [5:0]   src = '0;
    logic [63:0]  rs = '0;
    logic [127:0] xs = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [1:0]   out_sat, out_nan, out_bad_src;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;

    always #5 clk = ~clk;

    fpu_operand_stage #(.NUM_OPS(2), .DATA_W(64), .FRAC_W(48)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src         (src),
        .rs_data     (rs),
        .xs_data     (xs),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .out_nan     (out_nan),
        .out_bad_src (out_bad_src)
    );

    typedef struct {
        logic [127:0] data;
        logic [1:0]   sat;
        logic [1:0]   nan;
        logic [1:0]   bad;
    } exp_t;

    typedef struct {
        logic [5:0]   src;
        logic [63:0]  rs;
        logic [127:0] xs;
        exp_t         e;
    } vec_t;

    exp_t sb[$];

    // Value-level reference: real-number semantics evaluated with wide integers
    function automatic void model_op(input logic [2:0] s, input logic [31:0] r,
                                     input logic [63:0] x, output logic [63:0] d,
                                     output logic sat, output logic nan, output logic bad);
        longint       v;
        int           e;
        logic [191:0] mag;
        d = '0; sat = 1'b0; nan = 1'b0; bad = 1'b0;
        case (s)
            3'd0: d = '0;
            3'd1: d = 64'h0001_0000_0000_0000;
            3'd2: d = x;
            3'd3: begin
                e = int'(r[30:23]);
                if (e == 255) begin
                    if (r[22:0] != 0) nan = 1'b1;
                    else begin sat = 1'b1; d = r[31] ? MINV : MAXV; end
                end else if (e != 0) begin
                    mag = 192'({1'b1, r[22:0]});
                    if (e - 102 >= 0) mag = mag << (e - 102);
                    else              mag = mag >> (102 - e);
                    if (!r[31]) begin
                        if (mag > 192'(MAXV)) begin sat = 1'b1; d = MAXV; end
                        else d = mag[63:0];
                    end else begin
                        if (mag > (192'(1) << 63)) begin sat = 1'b1; d = MINV; end
                        else d = -mag[63:0];
                    end
                end
            end
            3'd4: begin
                v = longint'(r);
                if (v > 32767) begin sat = 1'b1; d = MAXV; end
                else d = 64'(v) << 48;
            end
            3'd5: begin
                v = longint'($signed(r));
                if (v > 32767)       begin sat = 1'b1; d = MAXV; end
                else if (v < -32768) begin sat = 1'b1; d = MINV; end
                else d = 64'(v) << 48;
            end
            default: bad = 1'b1;
        endcase
    endfunction

    function automatic exp_t model(input logic [5:0] s, input logic [63:0] r, input logic [127:0] x);
        exp_t        e;
        logic [63:0] d;
        logic        sa, na, ba;
        for (int i = 0; i < 2; i++) begin
            model_op(s[3*i +: 3], r[32*i +: 32], x[64*i +: 64], d, sa, na, ba);
            e.data[64*i +: 64] = d;
            e.sat[i] = sa;
            e.nan[i] = na;
            e.bad[i] = ba;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_rs();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: r[30:23] = 8'($urandom_range(95, 145));
            2: r[30:23] = 8'($urandom_range(140, 143));
            default: r = $urandom_range(0, 1) ? 32'($urandom_range(0, 40000))
                                              : -32'($urandom_range(0, 40000));
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_out(input string name, input exp_t e);
        chk({name, "_data"}, out_data, e.data);
        chk({name, "_sat"}, 128'(out_sat), 128'(e.sat));
        chk({name, "_nan"}, 128'(out_nan), 128'(e.nan));
        chk({name, "_bad"}, 128'(out_bad_src), 128'(e.bad));
    endtask

    // Called #1 after a negedge with inputs driven; scores the coming posedge
    task automatic step();
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) chk("unexpected_out", 128'(out_valid), 128'(0));
            else                chk_out("stream", sb[0]);
        end
        if (in_valid && in_ready) sb.push_back(model(src, rs, xs));
        if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            n_out++;
        end
        @(negedge clk);
    endtask

    vec_t tab[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  bp_src[5];
        logic [63:0] bp_rs[5];
        int k;
        int out0;

        tab[0]  = '{6'b011011, {32'hC000_0000, 32'h3FC0_0000}, '0,
                    '{{64'hFFFE_0000_0000_0000, 64'h0001_8000_0000_0000}, 2'b00, 2'b00, 2'b00}};
        tab[1]  = '{6'b101100, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, '0,
                    '{{64'hFFFF_0000_0000_0000, MAXV}, 2'b01, 2'b00, 2'b00}};
        tab[2]  = '{6'b101101, {32'h0000_8000, 32'hFFFF_8000}, '0,
                    '{{MAXV, MINV}, 2'b10, 2'b00, 2'b00}};
        tab[3]  = '{6'b011011, {32'hFF80_0000, 32'h7FC0_0000}, '0,
                    '{{MINV, 64'h0}, 2'b10, 2'b01, 2'b00}};
        tab[4]  = '{6'b111011, {32'h0, 32'h0000_0001}, '0,
                    '{128'h0, 2'b00, 2'b00, 2'b10}};
        tab[5]  = '{6'b001000, 64'h0, '0,
                    '{{64'h0001_0000_0000_0000, 64'h0}, 2'b00, 2'b00, 2'b00}};
        tab[6]  = '{6'b110010, 64'h0, {64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0},
                    '{{64'h0, 64'h1234_5678_9ABC_DEF0}, 2'b00, 2'b00, 2'b10}};
        tab[7]  = '{6'b011011, {32'hC700_0000, 32'h4700_0000}, '0,
                    '{{MINV, MAXV}, 2'b01, 2'b00, 2'b00}};
        tab[8]  = '{6'b011011, {32'h3F80_0000, 32'h46FF_FFFF}, '0,
                    '{{64'h0001_0000_0000_0000, 64'h7FFF_FF80_0000_0000}, 2'b00, 2'b00, 2'b00}};
        tab[9]  = '{6'b011011, {32'hA700_0000, 32'h27C0_0000}, '0,
                    '{{64'h0, 64'h1}, 2'b00, 2'b00, 2'b00}};
        tab[10] = '{6'b011011, {32'h7F80_0000, 32'h807F_FFFF}, '0,
                    '{{MAXV, 64'h0}, 2'b10, 2'b00, 2'b00}};
        tab[11] = '{6'b011011, {32'hC700_0001, 32'hC6FF_FFFF}, '0,
                    '{{MINV, 64'h8000_0080_0000_0000}, 2'b10, 2'b00, 2'b00}};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_flags", 128'({out_sat, out_nan, out_bad_src}), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        reset_n = 1'b1;
        @(negedge clk);

        // Directed table with latency check
        foreach (tab[i]) begin
            src = tab[i].src; rs = tab[i].rs; xs = tab[i].xs;
            in_valid = 1'b1; out_ready = 1'b1;
            #1 chk("tab_in_ready", 128'(in_ready), 128'(1));
            @(negedge clk);
            in_valid = 1'b0;
            #1 chk("tab_lat_early", 128'(out_valid), 128'(0));
            @(negedge clk);
            #1 chk("tab_out_valid", 128'(out_valid), 128'(1));
            chk_out("tab", tab[i].e);
            @(negedge clk);
        end

        // Back-pressure: 5 transactions, consumer stalled for the first cycles
        for (int i = 0; i < 5; i++) begin
            bp_src[i] = {3'($urandom_range(0, 5)), 3'($urandom_range(0, 5))};
            bp_rs[i]  = {rand_rs(), rand_rs()};
        end
        k = 0;
        out0 = n_out;
        for (int c = 0; c < 40 && (k < 5 || sb.size() > 0); c++) begin
            in_valid  = (k < 5);
            src       = (k < 5) ? bp_src[k] : 6'h0;
            rs        = (k < 5) ? bp_rs[k] : 64'h0;
            xs        = {$urandom, $urandom, $urandom, $urandom};
            out_ready = (c >= 6);
            #1;
            if (c >= 2 && c < 6) chk("bp_in_ready_low", 128'(in_ready), 128'(0));
            if (c == 2) chk("bp_accepted", 128'(k), 128'(2));
            if (in_valid && in_ready) k++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_delivered", 128'(n_out - out0), 128'(5));
        chk("bp_sb_empty", 128'(sb.size()), 128'(0));

        // Reset with pipe full of flagged transactions
        src = 6'b111100; rs = 64'hFFFF_FFFF_FFFF_FFFF; xs = '0;
        in_valid = 1'b1; out_ready = 1'b0;
        #1 step();
        #1 step();
        #1 chk("full_out_valid", 128'(out_valid), 128'(1));
        reset_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst2_out_valid", 128'(out_valid), 128'(0));
        chk("rst2_out_data", out_data, 128'h0);
        chk("rst2_flags", 128'({out_sat, out_nan, out_bad_src}), 128'(0));
        chk("rst2_in_ready", 128'(in_ready), 128'(1));
        reset_n = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1 chk("rst2_no_stale", 128'(out_valid), 128'(0));
            step();
        end

        // Randomized streaming with random back-pressure
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            src       = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            rs        = {rand_rs(), rand_rs()};
            xs        = {$urandom, $urandom, $urandom, $urandom};
            #1 step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            #1 step();
        end
        chk("drain_empty", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
